// File: rtl/twiddle_ctrl.sv
// twiddle_ctrl: block sequencer and twiddle ROM addressing for the 16-lane FFT twiddle multiplier
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_clr               synchronous abort back to IDLE, pipeline flushed
//   i_cfg_seg/shift     log2 segment length and exponent shift, latched on block 0
//   i_in_valid          upstream block valid; o_in_ready accepts it
//   o_tw_addr           per-lane ROM address for the block being accepted
//   o_rom_en, o_mul_en  ROM read enable and multiplier output register enable
//   o_out_valid/last    block present at the multiplier register, last = block 31
//   i_out_ready         downstream accept
//   o_blk_cnt, o_busy   next block index, state != IDLE
module twiddle_ctrl #(
    parameter int LANES  = 16,
    parameter int LOG2N  = 9,
    parameter int ADDR_W = LOG2N
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_clr,
    input  logic [3:0]                                i_cfg_seg,
    input  logic [3:0]                                i_cfg_shift,
    input  logic                                      i_in_valid,
    output logic                                      o_in_ready,
    output logic [LANES-1:0][ADDR_W-1:0]              o_tw_addr,
    output logic                                      o_rom_en,
    output logic                                      o_mul_en,
    output logic                                      o_out_valid,
    output logic                                      o_out_last,
    input  logic                                      i_out_ready,
    output logic [LOG2N-$clog2(LANES)-1:0]            o_blk_cnt,
    output logic                                      o_busy
);
    localparam int LW = $clog2(LANES);
    localparam int BW = LOG2N - LW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        r_state;
    logic [BW-1:0] r_blk_cnt;
    logic [3:0]    r_seg, r_shift;
    logic          r_s1_v, r_s1_l, r_s2_v, r_s2_l;
    logic          w_adv, w_acc;
    logic [3:0]    w_seg, w_shift;

    assign w_adv       = !r_s2_v || i_out_ready;
    // reset and clr both gate the handshake combinationally so nothing is accepted in those cycles
    assign o_in_ready  = i_rst_n && !i_clr && w_adv && r_state != DRAIN;
    assign w_acc       = i_in_valid && o_in_ready;
    assign o_rom_en    = w_acc;
    assign o_mul_en    = i_rst_n && !i_clr && w_adv && r_s1_v;
    assign o_out_valid = r_s2_v;
    assign o_out_last  = r_s2_l;
    assign o_blk_cnt   = r_blk_cnt;
    assign o_busy      = r_state != IDLE;
    // block 0 is addressed with the live config, the rest of the frame with the latched copy
    assign w_seg       = r_state == IDLE ? i_cfg_seg : r_seg;
    assign w_shift     = r_state == IDLE ? i_cfg_shift : r_shift;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LOG2N-1:0]   w_p, w_r, w_q;
        logic [2*LOG2N-1:0] w_prod;
        assign w_p    = {r_blk_cnt, LW'(g)};
        // a segment of 2^LOG2N or more leaves the mask all ones and q = 0
        assign w_r    = w_p & ((LOG2N'(1) << w_seg) - LOG2N'(1));
        assign w_q    = w_p >> w_seg;
        assign w_prod = {{LOG2N{1'b0}}, w_r} * {{LOG2N{1'b0}}, w_q};
        assign o_tw_addr[g] = i_rst_n ? ADDR_W'(w_prod << w_shift) : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_blk_cnt <= '0;
            r_seg     <= '0;
            r_shift   <= '0;
            r_s1_v    <= 1'b0;
            r_s1_l    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s2_l    <= 1'b0;
        end else if (i_clr) begin
            r_state   <= IDLE;
            r_blk_cnt <= '0;
            r_s1_v    <= 1'b0;
            r_s1_l    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s2_l    <= 1'b0;
        end else begin
            if (w_adv) begin
                r_s2_v <= r_s1_v;
                r_s2_l <= r_s1_l;
                r_s1_v <= w_acc;
                r_s1_l <= w_acc && &r_blk_cnt;
            end
            case (r_state)
                IDLE: if (w_acc) begin
                    r_state   <= RUN;
                    r_seg     <= i_cfg_seg;
                    r_shift   <= i_cfg_shift;
                    r_blk_cnt <= r_blk_cnt + BW'(1);
                end
                RUN: if (w_acc) begin
                    r_blk_cnt <= r_blk_cnt + BW'(1);
                    if (&r_blk_cnt) r_state <= DRAIN;
                end
                DRAIN: if (!r_s1_v && !r_s2_v) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_twiddle_ctrl.sv
// tb_twiddle_ctrl: directed vectors and multi-cycle sequences for twiddle_ctrl
module tb_twiddle_ctrl;
    localparam int LANES = 16, LOG2N = 9, ADDR_W = 9;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0] cfg_seg = 4'd0, cfg_shift = 4'd0;
    logic in_ready, rom_en, mul_en, out_valid, out_last, busy;
    logic [LANES-1:0][ADDR_W-1:0] tw_addr;
    logic [4:0] blk_cnt;

    twiddle_ctrl #(.LANES(LANES), .LOG2N(LOG2N), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_cfg_seg(cfg_seg), .i_cfg_shift(cfg_shift),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .o_tw_addr(tw_addr), .o_rom_en(rom_en),
        .o_mul_en(mul_en), .o_out_valid(out_valid), .o_out_last(out_last), .i_out_ready(out_ready),
        .o_blk_cnt(blk_cnt), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int seg; int shift; int blk; int lane; int exp;} vec_t;
    vec_t tv[11];

    int n_tests = 0, n_fail = 0, n_out = 0;
    int m_state, m_cnt, m_seg, m_shift, last_blk;
    bit m_s1, m_l1, m_s2, m_l2, last_acc;

    function automatic int ref_addr(int seg, int shift, int blk, int lane);
        int p, s;
        p = blk * LANES + lane;
        s = 1 << seg;
        return (((p % s) * (p / s)) << shift) % 512;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [LANES-1:0][ADDR_W-1:0] act,
                           input logic [LANES-1:0][ADDR_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_cnt = 0; m_s1 = 0; m_l1 = 0; m_s2 = 0; m_l2 = 0;
    endtask

    // one clock: check outputs against the reference model, then step the model across the edge
    task automatic cyc();
        bit adv, rdy, acc, s1o, s2o;
        int seg, shift;
        logic [LANES-1:0][ADDR_W-1:0] e;
        #1;
        adv   = !m_s2 || out_ready;
        rdy   = !clr && adv && m_state != 2;
        acc   = in_valid && rdy;
        seg   = m_state == 0 ? int'(cfg_seg) : m_seg;
        shift = m_state == 0 ? int'(cfg_shift) : m_shift;
        chk("in_ready", in_ready, rdy);
        chk("rom_en", rom_en, acc);
        chk("mul_en", mul_en, !clr && adv && m_s1);
        chk("out_valid", out_valid, m_s2);
        chk("out_last", out_last, m_l2);
        chk("blk_cnt", blk_cnt, m_cnt);
        chk("busy", busy, m_state != 0);
        if (acc) begin
            for (int l = 0; l < LANES; l++) e[l] = ADDR_W'(ref_addr(seg, shift, m_cnt, l));
            chk_vec($sformatf("tw_addr blk %0d", m_cnt), tw_addr, e);
        end
        if (out_valid && out_ready) n_out++;
        last_acc = acc;
        last_blk = m_cnt;
        s1o = m_s1;
        s2o = m_s2;
        @(posedge clk);
        #1;
        if (clr) m_reset();
        else begin
            if (adv) begin
                m_s2 = m_s1; m_l2 = m_l1; m_s1 = acc; m_l1 = acc && m_cnt == 31;
            end
            case (m_state)
                0: if (acc) begin m_state = 1; m_seg = seg; m_shift = shift; m_cnt = 1; end
                1: if (acc) begin
                    if (m_cnt == 31) begin m_cnt = 0; m_state = 2; end
                    else m_cnt++;
                end
                default: if (!s1o && !s2o) m_state = 0;
            endcase
        end
    endtask

    task automatic finish_frame(input string name, input int exp_out);
        for (int k = 0; k < 80 && m_state != 2; k++) cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && m_state != 0; k++) cyc();
        chk(name, n_out, exp_out);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t31, t0, gap;
        tv[0]  = '{4, 0, 0, 9, 0};
        tv[1]  = '{4, 0, 1, 0, 0};
        tv[2]  = '{4, 0, 1, 7, 7};
        tv[3]  = '{4, 0, 1, 15, 15};
        tv[4]  = '{4, 0, 5, 3, 15};
        tv[5]  = '{8, 1, 31, 15, 510};
        tv[6]  = '{0, 3, 17, 9, 0};
        tv[7]  = '{2, 0, 2, 5, 9};
        tv[8]  = '{3, 2, 10, 6, 480};
        tv[9]  = '{5, 3, 20, 13, 16};
        tv[10] = '{8, 0, 17, 1, 17};
        m_reset();

        // reset values, with a config that would give non-zero addresses if ungated
        cfg_seg = 4'd2;
        in_valid = 1'b1;
        #12;
        chk("reset in_ready", in_ready, 0);
        chk("reset rom_en", rom_en, 0);
        chk("reset mul_en", mul_en, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_last", out_last, 0);
        chk("reset busy", busy, 0);
        chk("reset blk_cnt", blk_cnt, 0);
        chk_vec("reset tw_addr", tw_addr, '0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("in_ready after release", in_ready, 1);
        @(posedge clk);
        #1;

        // directed address vectors; config is scrambled after block 0 and must be ignored
        for (int j = 0; j < 11; j++) begin
            clr = 1'b1;
            in_valid = 1'b0;
            cyc();
            clr = 1'b0;
            cfg_seg = 4'(tv[j].seg);
            cfg_shift = 4'(tv[j].shift);
            in_valid = 1'b1;
            for (int k = 0; k < 40 && m_cnt != tv[j].blk; k++) begin
                cyc();
                if (k == 0) begin
                    cfg_seg = 4'(tv[j].seg ^ 3);
                    cfg_shift = 4'(tv[j].shift ^ 5);
                end
            end
            #1;
            chk($sformatf("vec%0d in_ready", j), in_ready, 1);
            chk($sformatf("vec%0d tw_addr[%0d] blk %0d", j, tv[j].lane, tv[j].blk),
                tw_addr[tv[j].lane], tv[j].exp);
        end
        clr = 1'b1;
        in_valid = 1'b0;
        cyc();
        clr = 1'b0;

        // full frame, no stalls
        n_out = 0;
        cfg_seg = 4'd4;
        cfg_shift = 4'd0;
        in_valid = 1'b1;
        finish_frame("frame outputs", 32);

        // 5-cycle output stall mid-frame plus ignored config change
        n_out = 0;
        cfg_seg = 4'd8;
        cfg_shift = 4'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) cyc();
        cfg_seg = 4'd2;
        cfg_shift = 4'd7;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k == 2) begin
                chk("stall in_ready", in_ready, 0);
                chk("stall out_valid", out_valid, 1);
            end
        end
        out_ready = 1'b1;
        finish_frame("stall frame outputs", 32);

        // back-to-back frames, second frame latches the new config
        n_out = 0;
        cfg_seg = 4'd5;
        cfg_shift = 4'd2;
        in_valid = 1'b1;
        t31 = -1;
        t0 = -1;
        gap = 0;
        for (int k = 0; k < 90; k++) begin
            cyc();
            if (k == 0) begin
                cfg_seg = 4'd3;
                cfg_shift = 4'd1;
            end
            if (last_acc && last_blk == 31 && t31 < 0) t31 = k;
            if (t31 >= 0 && t0 < 0 && !busy) gap++;
            if (t31 >= 0 && t0 < 0 && last_acc && last_blk == 0) t0 = k;
            if (t0 >= 0 && m_state == 2) break;
        end
        chk("frame gap cycles", t0 - t31, 4);
        chk("busy low between frames", int'(gap >= 1), 1);
        finish_frame("b2b outputs", 64);

        // clr with both stages full at block 12
        n_out = 0;
        cfg_seg = 4'd6;
        cfg_shift = 4'd4;
        in_valid = 1'b1;
        for (int k = 0; k < 40 && !(m_cnt == 12 && m_s1 && m_s2); k++) cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr out_valid", out_valid, 0);
        chk("clr blk_cnt", blk_cnt, 0);
        chk("clr busy", busy, 0);
        for (int k = 0; k < 2; k++) cyc();
        n_out = 0;
        in_valid = 1'b1;
        finish_frame("post-clr frame outputs", 32);

        // asynchronous reset between edges mid-frame
        n_out = 0;
        cfg_seg = 4'd7;
        cfg_shift = 4'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) cyc();
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async in_ready", in_ready, 0);
        chk("async rom_en", rom_en, 0);
        chk("async mul_en", mul_en, 0);
        chk("async out_valid", out_valid, 0);
        chk("async out_last", out_last, 0);
        chk("async busy", busy, 0);
        chk("async blk_cnt", blk_cnt, 0);
        chk_vec("async tw_addr", tw_addr, '0);
        m_reset();
        #2;
        rst_n = 1'b1;
        #1;
        chk("async release in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) cyc();
        n_out = 0;
        in_valid = 1'b1;
        finish_frame("post-reset frame outputs", 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
